// File: rtl/ground_pkg.sv
// Shared definitions for the ground crumble sequencer: frame codes,
// per-tile state encoding and the state -> output decode helpers.
package ground_pkg;

  // Frame codes presented to the ground display / ROM-mux layer.
  localparam logic [1:0] FRAME_INTACT = 2'd0;
  localparam logic [1:0] FRAME_CRACK1 = 2'd1;
  localparam logic [1:0] FRAME_CRACK2 = 2'd2;
  localparam logic [1:0] FRAME_GONE   = 2'd3;

  // Per-tile animation state.
  typedef enum logic [2:0] {
    TILE_IDLE   = 3'd0,
    TILE_ARMED  = 3'd1,
    TILE_CRACK1 = 3'd2,
    TILE_CRACK2 = 3'd3,
    TILE_GONE   = 3'd4
  } tile_state_e;

  // Frame code shown while a tile sits in a given state.
  function automatic logic [1:0] frame_of(input tile_state_e s);
    logic [1:0] f;
    case (s)
      TILE_IDLE:   f = FRAME_INTACT;
      TILE_ARMED:  f = FRAME_INTACT;
      TILE_CRACK1: f = FRAME_CRACK1;
      TILE_CRACK2: f = FRAME_CRACK2;
      TILE_GONE:   f = FRAME_GONE;
      default:     f = FRAME_INTACT;
    endcase
    return f;
  endfunction

  // A tile stays collidable until it has fully crumbled.
  function automatic logic solid_of(input tile_state_e s);
    return (s != TILE_GONE);
  endfunction

endpackage

// File: rtl/ground_tile_fsm.sv
// One breakable ground tile: IDLE -> ARMED -> CRACK1 -> CRACK2 -> GONE,
// advancing on the shared frame tick. All outputs are registered and are
// decoded from the next state so they change on the same edge as the state.
module ground_tile_fsm
  import ground_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       touched,
  input  logic       tick,
  input  logic       restart,
  output logic [1:0] frame,
  output logic       solid,
  output logic       gone_pulse,
  output logic       is_gone
);

  tile_state_e state_q, state_d;
  logic [1:0]  frame_q, frame_d;
  logic        solid_q, solid_d;
  logic        gone_pulse_q, gone_pulse_d;
  logic        is_gone_q, is_gone_d;

  // Next-state logic; restart overrides both tick and touch.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = TILE_IDLE;
    end else begin
      case (state_q)
        // A tick arriving with the first touch is not consumed: arm only.
        TILE_IDLE:   if (touched) state_d = TILE_ARMED;
        TILE_ARMED:  if (tick)    state_d = TILE_CRACK1;
        TILE_CRACK1: if (tick)    state_d = TILE_CRACK2;
        TILE_CRACK2: if (tick)    state_d = TILE_GONE;
        TILE_GONE:                state_d = TILE_GONE;
        default:                  state_d = TILE_IDLE;
      endcase
    end
  end

  // Output decode from the next state so outputs track state transitions.
  always_comb begin
    frame_d      = frame_of(state_d);
    solid_d      = solid_of(state_d);
    gone_pulse_d = (state_q == TILE_CRACK2) && (state_d == TILE_GONE);
    is_gone_d    = (state_d == TILE_GONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TILE_IDLE;
      frame_q      <= FRAME_INTACT;
      solid_q      <= 1'b1;
      gone_pulse_q <= 1'b0;
      is_gone_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      solid_q      <= solid_d;
      gone_pulse_q <= gone_pulse_d;
      is_gone_q    <= is_gone_d;
    end
  end

  assign frame      = frame_q;
  assign solid      = solid_q;
  assign gone_pulse = gone_pulse_q;
  assign is_gone    = is_gone_q;

endmodule

// File: rtl/ground_crumble_ctrl.sv
// Crumble animation scheduler for N breakable ground tiles: one shared,
// pausable frame-advance divider feeding one FSM per tile, plus the
// registered "every tile gone" flag.
module ground_crumble_ctrl
  import ground_pkg::*;
#(
  parameter int N_TILES     = 3,
  parameter int TICK_CYCLES = 6000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_TILES-1:0]     bk_touched,
  input  logic                   restart,
  input  logic                   pause,
  output logic [2*N_TILES-1:0]   frame_sel,
  output logic [N_TILES-1:0]     solid,
  output logic [N_TILES-1:0]     gone_pulse,
  output logic                   all_gone
);

  localparam int              CNT_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [N_TILES-1:0] tile_gone;
  logic               all_gone_q, all_gone_d;

  // Frame strobe: last divider count while not paused.
  always_comb begin
    tick = (cnt_q == CNT_LAST) && !pause;
  end

  // Divider next count: restart clears, pause holds, otherwise wrap at the end.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (!pause) begin
      if (cnt_q == CNT_LAST) cnt_d = '0;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // One animation FSM per tile.
  for (genvar gi = 0; gi < N_TILES; gi++) begin : g_tile
    ground_tile_fsm u_tile (
      .clk        (clk),
      .rst_n      (rst_n),
      .touched    (bk_touched[gi]),
      .tick       (tick),
      .restart    (restart),
      .frame      (frame_sel[2*gi +: 2]),
      .solid      (solid[gi]),
      .gone_pulse (gone_pulse[gi]),
      .is_gone    (tile_gone[gi])
    );
  end

  // The per-tile gone flags are already registered, so this flag lags the
  // last tile entering GONE by one cycle; restart must clear it directly.
  always_comb begin
    all_gone_d = restart ? 1'b0 : (&tile_gone);
  end

  // all_gone register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_gone_q <= 1'b0;
    else        all_gone_q <= all_gone_d;
  end

  assign all_gone = all_gone_q;

endmodule

// File: tb/tb_ground_crumble_ctrl.sv
// Self-checking bench for ground_crumble_ctrl (N_TILES = 3, TICK_CYCLES = 4).
// A cycle model pushes expected outputs on every rising edge; they are
// popped and compared on the falling edge. Directed checks cover latencies.
module tb_ground_crumble_ctrl;

  localparam int NT   = 3;
  localparam int TICK = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NT-1:0] bk_touched = '0;
  logic          restart = 1'b0;
  logic          pause = 1'b0;
  logic [2*NT-1:0] frame_sel;
  logic [NT-1:0] solid;
  logic [NT-1:0] gone_pulse;
  logic          all_gone;

  int n_assert = 0;
  int n_fail   = 0;

  ground_crumble_ctrl #(.N_TILES(NT), .TICK_CYCLES(TICK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bk_touched (bk_touched),
    .restart    (restart),
    .pause      (pause),
    .frame_sel  (frame_sel),
    .solid      (solid),
    .gone_pulse (gone_pulse),
    .all_gone   (all_gone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 armed, 2 crack1, 3 crack2, 4 gone
  int         m_phase[NT];
  int         m_div = 0;
  logic [NT-1:0] m_gp = '0;
  logic       m_ag = 1'b0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] model_outputs();
    logic [5:0] f;
    logic [2:0] s;
    f = '0;
    s = '0;
    for (int i = 0; i < NT; i++) begin
      f[2*i +: 2] = (m_phase[i] < 2) ? 2'd0 : 2'(m_phase[i] - 1);
      s[i]        = (m_phase[i] != 4);
    end
    return {f, s, m_gp, m_ag};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_phase[i] = 0;
    m_div = 0;
    m_gp  = '0;
    m_ag  = 1'b0;
  endtask

  initial model_reset();

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    int  old[NT];
    bit  tk;
    bit  allg;
    if (!rst_n) begin
      model_reset();
    end else begin
      tk   = (m_div == TICK - 1) && !pause;
      allg = 1'b1;
      for (int i = 0; i < NT; i++) begin
        old[i] = m_phase[i];
        if (old[i] != 4) allg = 1'b0;
      end
      if (restart) begin
        model_reset();
      end else begin
        m_ag = allg;
        for (int i = 0; i < NT; i++) begin
          m_gp[i] = (old[i] == 3) && tk;
          if (old[i] == 0) m_phase[i] = bk_touched[i] ? 1 : 0;
          else if (old[i] < 4 && tk) m_phase[i] = old[i] + 1;
        end
        if (!pause) m_div = tk ? 0 : m_div + 1;
      end
    end
    exp_q.push_back(model_outputs());
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_frame_sel",  32'(frame_sel),  32'(e[12:7]));
      check("sb_solid",      32'(solid),      32'(e[6:4]));
      check("sb_gone_pulse", 32'(gone_pulse), 32'(e[3:1]));
      check("sb_all_gone",   32'(all_gone),   32'(e[0]));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_frame(input int t, input logic [1:0] v, input int maxc,
                            input string tag, output int n);
    n = 0;
    while (frame_sel[2*t +: 2] !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frame_sel[2*t +: 2]), 32'(v));
  endtask

  task automatic wait_div(input int v);
    int n;
    n = 0;
    while (m_div != v && n < 2 * TICK) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int d;

    // reset values while rst_n is held low
    @(negedge clk);
    check("rst_frame_sel",  32'(frame_sel),  32'h0);
    check("rst_solid",      32'(solid),      32'h7);
    check("rst_gone_pulse", 32'(gone_pulse), 32'h0);
    check("rst_all_gone",   32'(all_gone),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle: nothing moves
    repeat (20) @(negedge clk);
    check("idle_frame_sel", 32'(frame_sel), 32'h0);
    check("idle_solid",     32'(solid),     32'h7);

    // tile0 touched for one cycle mid-count, then released
    wait_div(1);
    bk_touched = 3'b001;
    @(negedge clk);
    bk_touched = 3'b000;
    wait_frame(0, 2'd1, 8, "t0_crack1", n);
    check("t0_crack1_latency", 32'(n), 32'd2);
    wait_frame(0, 2'd2, 8, "t0_crack2", n);
    check("t0_crack1_to_crack2", 32'(n), 32'd4);
    wait_frame(0, 2'd3, 8, "t0_gone", n);
    check("t0_crack2_to_gone", 32'(n), 32'd4);
    check("t0_solid_low",      32'(solid),      32'h6);
    check("t0_gone_pulse",     32'(gone_pulse), 32'h1);
    check("t12_frames_zero",   32'(frame_sel[5:2]), 32'h0);
    @(negedge clk);
    check("t0_gone_pulse_one_cycle", 32'(gone_pulse), 32'h0);
    check("t0_gone_sticky",          32'(frame_sel),  32'h3);

    // restart, then touch tile1 in a tick cycle
    pulse_restart();
    check("restart1_frame_sel", 32'(frame_sel), 32'h0);
    check("restart1_solid",     32'(solid),     32'h7);
    wait_div(TICK - 1);
    bk_touched = 3'b010;
    @(negedge clk);
    bk_touched = 3'b000;
    check("t1_armed_frame0", 32'(frame_sel[3:2]), 32'h0);
    wait_frame(1, 2'd1, 8, "t1_crack1", n);
    check("t1_arm_to_crack1", 32'(n), 32'd4);

    // all three tiles
    pulse_restart();
    bk_touched = 3'b111;
    @(negedge clk);
    bk_touched = 3'b000;
    n = 0;
    while (frame_sel !== 6'h3F && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("all_frames_gone",       32'(frame_sel),  32'h3F);
    check("all_gone_pulse",        32'(gone_pulse), 32'h7);
    check("all_gone_not_yet",      32'(all_gone),   32'h0);
    @(negedge clk);
    check("all_gone_rises",        32'(all_gone),   32'h1);
    check("all_gone_pulse_clears", 32'(gone_pulse), 32'h0);
    check("all_solid_low",         32'(solid),      32'h0);

    // pause while tile0 is in CRACK1
    pulse_restart();
    check("restart2_all_gone", 32'(all_gone), 32'h0);
    bk_touched = 3'b001;
    @(negedge clk);
    bk_touched = 3'b000;
    wait_frame(0, 2'd1, 8, "pause_t0_crack1", n);
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("pause_frame_held", 32'(frame_sel[1:0]), 32'h1);
    end
    d = m_div;
    pause = 1'b0;
    wait_frame(0, 2'd2, 12, "pause_t0_crack2", n);
    check("pause_resume_remaining", 32'(n), 32'(TICK - d));

    // restart in CRACK2 with a simultaneous touch on tile2
    restart    = 1'b1;
    bk_touched = 3'b100;
    @(negedge clk);
    restart    = 1'b0;
    bk_touched = 3'b000;
    check("restart3_frame_sel",  32'(frame_sel),  32'h0);
    check("restart3_solid",      32'(solid),      32'h7);
    check("restart3_gone_pulse", 32'(gone_pulse), 32'h0);
    check("restart3_all_gone",   32'(all_gone),   32'h0);
    repeat (8) @(negedge clk);
    check("t2_touch_dropped", 32'(frame_sel), 32'h0);

    // asynchronous reset mid-animation
    bk_touched = 3'b011;
    @(negedge clk);
    bk_touched = 3'b000;
    wait_frame(0, 2'd1, 8, "areset_t0_crack1", n);
    #2 rst_n = 1'b0;
    #1;
    check("areset_frame_sel",  32'(frame_sel),  32'h0);
    check("areset_solid",      32'(solid),      32'h7);
    check("areset_gone_pulse", 32'(gone_pulse), 32'h0);
    check("areset_all_gone",   32'(all_gone),   32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_idle", 32'(frame_sel), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ground_crumble_ctrl.md
Name: ground_crumble_ctrl

Overview:
- Sequences the crumble animation of N breakable ground tiles.
- Owns the shared frame-advance divider and one state machine per tile.
- Per tile, drives a 2-bit frame select into the ground display/ROM-mux layer and a solid flag into collision logic.
- Replaces ad-hoc per-tile frame counters with one scheduler that supports restart and pause.

Parameters:
- N_TILES, 3, number of independently animated ground tiles.
- TICK_CYCLES, 6000000, clk cycles per animation frame step; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- bk_touched  in  N_TILES  level; bit i high = player standing on tile i.
- restart  in  1  one-cycle pulse; level restart, all tiles intact.
- pause  in  1  level; freezes the divider.
- frame_sel  out  2*N_TILES  tile i frame code in bits [2i+1:2i].
- solid  out  N_TILES  tile i collidable.
- gone_pulse  out  N_TILES  one-cycle pulse when tile i becomes GONE.
- all_gone  out  1  high while every tile is GONE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - divider count = 0, all tiles IDLE.
  - frame_sel = 0, solid = all 1, gone_pulse = 0, all_gone = 0.
- Divider:
  - cnt counts 0..TICK_CYCLES-1; width is $clog2(TICK_CYCLES).
  - tick is a one-cycle internal strobe while cnt == TICK_CYCLES-1 and pause = 0; cnt wraps to 0 on that cycle.
  - pause = 1 holds cnt and suppresses tick.
  - restart clears cnt to 0.
- Per-tile FSM, all outputs registered:
  - IDLE: frame 0, solid 1. bk_touched[i] = 1 -> ARMED. A tick in the same cycle is not consumed.
  - ARMED: frame 0, solid 1. tick -> CRACK1. Touch is latched; releasing bk_touched does not return to IDLE.
  - CRACK1: frame 1, solid 1. tick -> CRACK2.
  - CRACK2: frame 2, solid 1. tick -> GONE.
  - GONE: frame 3, solid 0. Sticky until restart; touches ignored.
- Frame codes: 0 = intact, 1 = crack1, 2 = crack2, 3 = gone (display blanks the tile).
- Latency:
  - Touch sampled at edge t -> state ARMED after edge t; outputs unchanged (frame 0).
  - Each later transition updates frame_sel/solid on the same edge that changes state.
  - gone_pulse[i] is high for exactly the one cycle after the CRACK2 -> GONE edge.
- all_gone: registered AND of all per-tile GONE flags; changes one cycle after the last tile enters GONE.
- restart has highest priority, over tick and touch:
  - Next edge: all tiles IDLE, cnt 0, gone_pulse 0, all_gone 0.
  - A touch in the restart cycle is dropped.
- Tiles are independent; any number may advance on the same tick.
- pause mid-animation: state and frame held; resumes from the held cnt value.
- Reset mid-animation returns to the reset values immediately.

Decomposition:
- Shared package ground_pkg:
  - Frame code constants FRAME_INTACT = 2'd0, FRAME_CRACK1 = 2'd1, FRAME_CRACK2 = 2'd2, FRAME_GONE = 2'd3.
  - Tile state encoding.
- Sub-module ground_tile_fsm: one tile's FSM.
  - Inputs: clk, rst_n, touched, tick, restart.
  - Outputs: frame, solid, gone_pulse, is_gone.
  - Instantiated N_TILES times in a generate loop.
- Divider and all_gone reduction live in the top level.

Test Plan (TICK_CYCLES = 4, N_TILES = 3):
- Reset, then idle 20 cycles -> frame_sel = 0, solid = 3'b111, gone_pulse = 0, all_gone = 0 throughout.
- bk_touched = 3'b001 for 1 cycle mid-count, then released:
  - tile0 frame goes 1, 2, 3 on three successive ticks, 4 cycles apart.
  - solid[0] falls with frame 3.
  - gone_pulse[0] high exactly 1 cycle.
  - tiles 1 and 2 stay 0.
- Touch tile1 in the same cycle as a tick -> tile1 is ARMED and still frame 0; frame 1 appears on the next tick, 4 cycles later.
- Touch all three tiles -> frame_sel = 6'b111111 after three ticks; all_gone rises 1 cycle after gone_pulse = 3'b111.
- Assert pause for 10 cycles while tile0 is in CRACK1 -> frame stays 1, cnt frozen; after release, CRACK2 follows after the remaining count.
- restart while tile0 is in CRACK2 and bk_touched[2] = 1 in the same cycle:
  - next cycle: all frames 0, solid = 3'b111, tile2 IDLE.
  - rst_n pulsed low mid-animation: outputs return to reset values asynchronously.
